spike_window_scheduler: RTL and testbench
=========================================

# spike_window_scheduler

Multi-channel spike-count scheduler. It counts spike rising edges on N_CH channels over fixed-length windows, snapshots all counts at the window boundary, and serialises the snapshot to a single consumer over a valid/ready port, one channel per transfer, in channel order. It replaces per-channel free-running slow-clock counters with one synchronous controller that owns the window timing, count clearing and readout sequencing for the sensor-array datapath.

## Interface
- N_CH, 4, number of spike channels (1..16)
- CNT_W, 32, count width per channel
- LEN_W, 32, width of window_len
- CH_W, 4, width of out_ch (must hold N_CH-1)

- clk  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  high: windows run; low: timer and live counts held at 0
- window_len  in  LEN_W  window length in clk cycles; sampled at window start; values <2 treated as 2
- spike  in  N_CH  spike levels, synchronous to clk; each 0->1 transition counts as one spike
- window_tick  out  1  one-cycle pulse on the last cycle of each window
- out_valid  out  1  snapshot word available
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- out_ch  out  CH_W  channel index of the current word
- out_cnt  out  CNT_W  spike count of out_ch for the completed window
- busy  out  1  readout FSM not IDLE
- overrun  out  1  sticky: a window ended while the previous readout was still in progress

## Operation
- Edge detect: spike_d registered per channel; edge[i] = spike[i] & ~spike_d[i]; spike_d resets to 0.
- Window timer: counts 0..len-1, where len is the window_len value latched when the timer is at 0. window_tick = enable && timer == len-1. On the tick the timer returns to 0.
- Live counters: +1 per edge and saturate at 2^CNT_W-1. On the tick cycle the counter reloads to edge[i] (0 or 1), so a spike coinciding with the boundary is counted in the new window.
- Snapshot: on the tick, if FSM is IDLE, snap[i] <= live count including that cycle's edge. If FSM is not IDLE, the snapshot is not overwritten, that window's data is dropped and overrun is set. The live counters still reload.
- FSM states:
  - IDLE: if a tick occurs, go to SEND with ch=0.
  - SEND: out_valid=1, out_ch=ch, out_cnt=snap[ch]. On transfer, if ch==N_CH-1 go to IDLE, else ch+1.
- out_ch and out_cnt are stable while out_valid && !out_ready.
- enable low: timer and live counters held at 0 and window_tick suppressed. An in-progress readout completes normally. When enable rises, the window starts at timer 0 with window_len latched.
- overrun clears only on reset.

## Timing
- Reset values: window_tick=0, out_valid=0, out_ch=0, out_cnt=0, busy=0, overrun=0. Timer, live counters, snapshots and spike_d are all 0; FSM is IDLE.
- Reset asserted mid-readout aborts it immediately; out_valid goes low asynchronously.
- Spike-to-count latency: an edge in cycle t is included in the live count at the edge ending cycle t.
- Boundary to output: the tick is in cycle T; out_valid=1 with out_ch=0 in cycle T+1.
- Readout lasts at least N_CH cycles with out_ready held high (one word per cycle).
- The earliest next tick is at T+len. With len >= N_CH+1 and out_ready held high, no overrun is possible.
- A tick in the same cycle as the final transfer (ch==N_CH-1 accepted) is treated as busy: overrun is set and that window is dropped.
- Minimum spike period that counts every spike: 2 cycles (high, low).

## Test plan
- Basic count: N_CH=4, window_len=20, out_ready=1; ch0 pulses 3x, ch2 pulses 5x within the window -> words (0,3),(1,0),(2,5),(3,0), starting the cycle after window_tick.
- Boundary spike: ch1 rising edge exactly on the window_tick cycle -> counted in the current snapshot (count 1). The next window, with no further spikes, also reports 1.
- Backpressure: out_ready low for 7 cycles after out_valid rises -> out_ch=0 and out_cnt held constant; words then drain in order; busy drops after the 4th transfer.
- Overrun: window_len=6, out_ready=0 -> at the second tick overrun=1 and the snapshot is unchanged. After out_ready=1, the first window's values are delivered. overrun stays 1 until reset.
- Saturation and small length: CNT_W=3, 10 spikes in one window -> out_cnt=7. window_len=0 -> a tick every 2 cycles.
- Reset mid-readout: assert reset while out_ch=2 -> all outputs 0 and busy=0. After release, the first tick sends ch0 with counts only from after the release.

Source files
------------

// File: rtl/spike_window_scheduler.sv
// spike_window_scheduler
// Counts spike rising edges per channel over fixed-length windows, snapshots
// the counts at each window boundary and streams the snapshot out one channel
// per valid/ready transfer, in channel order.
module spike_window_scheduler #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int LEN_W = 32,
    parameter int CH_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [LEN_W-1:0] window_len,
    input  logic [N_CH-1:0]  spike,
    output logic             window_tick,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [CNT_W-1:0] out_cnt,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] timer;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_eff;
    logic             tick;
    logic [N_CH-1:0]  spike_d;
    logic [N_CH-1:0]  rise;
    logic [CNT_W-1:0] live     [N_CH];
    logic [CNT_W-1:0] live_inc [N_CH];
    logic [CNT_W-1:0] snap     [N_CH];
    logic [CNT_W-1:0] next_word;
    logic [CH_W-1:0]  ch;

    // Window length: sampled live at timer 0, held for the rest of the window, minimum 2
    always_comb begin
        len_eff = (timer == '0) ? window_len : len_q;
        if (len_eff < LEN_W'(2)) begin
            len_eff = LEN_W'(2);
        end
        tick = enable && (timer == len_eff - LEN_W'(1));
    end

    // Per-channel rising-edge detect and saturating increment including this cycle's edge
    always_comb begin
        rise = spike & ~spike_d;
        for (int unsigned i = 0; i < N_CH; i++) begin
            live_inc[i] = (rise[i] && (live[i] != '1)) ? live[i] + CNT_W'(1) : live[i];
        end
    end

    // Snapshot word for the channel following the one currently presented
    always_comb begin
        next_word = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (CH_W'(i) == ch + CH_W'(1)) begin
                next_word = snap[i];
            end
        end
    end

    // Window timer: runs 0..len-1 while enabled, parked at 0 otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
            len_q <= '0;
        end else begin
            if (timer == '0) begin
                len_q <= len_eff;
            end
            if (!enable || tick) begin
                timer <= '0;
            end else begin
                timer <= timer + LEN_W'(1);
            end
        end
    end

    // Live counters and snapshot capture; a boundary edge lands in both windows
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spike_d <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                live[i] <= '0;
                snap[i] <= '0;
            end
        end else begin
            spike_d <= spike;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (!enable) begin
                    live[i] <= '0;
                end else if (tick) begin
                    live[i] <= CNT_W'(rise[i]);
                end else begin
                    live[i] <= live_inc[i];
                end
                if (tick && (state == IDLE)) begin
                    snap[i] <= live_inc[i];
                end
            end
        end
    end

    // Readout FSM with registered channel/count outputs and sticky overrun flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ch      <= '0;
            out_cnt <= '0;
            overrun <= 1'b0;
        end else begin
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        state   <= SEND;
                        ch      <= '0;
                        out_cnt <= live_inc[0];
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (ch == CH_W'(N_CH - 1)) begin
                            state   <= IDLE;
                            ch      <= '0;
                            out_cnt <= '0;
                        end else begin
                            ch      <= ch + CH_W'(1);
                            out_cnt <= next_word;
                        end
                    end
                end
            endcase
        end
    end

    assign window_tick = tick;
    assign out_valid   = (state == SEND);
    assign busy        = (state == SEND);
    assign out_ch      = ch;

endmodule

// File: tb/tb_spike_window_scheduler.sv
// Directed testbench for spike_window_scheduler (N_CH=4, CNT_W=3).
module tb_spike_window_scheduler;

    localparam int N_CH  = 4;
    localparam int CNT_W = 3;
    localparam int LEN_W = 32;
    localparam int CH_W  = 4;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [LEN_W-1:0] window_len;
    logic [N_CH-1:0]  spike;
    logic             window_tick;
    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_ch;
    logic [CNT_W-1:0] out_cnt;
    logic             busy;
    logic             overrun;

    int unsigned errors = 0;
    int unsigned checks = 0;

    spike_window_scheduler #(
        .N_CH (N_CH),
        .CNT_W(CNT_W),
        .LEN_W(LEN_W),
        .CH_W (CH_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .window_len (window_len),
        .spike      (spike),
        .window_tick(window_tick),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_cnt    (out_cnt),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after posedge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        for (int n = 0; n < 64; n++) begin
            if (window_tick) break;
            step();
        end
        chk("tick_seen", window_tick, 1);
    endtask

    task automatic expect_words(input int unsigned c0, input int unsigned c1,
                                input int unsigned c2, input int unsigned c3);
        int unsigned exp_c[4];
        exp_c = '{c0, c1, c2, c3};
        for (int i = 0; i < 4; i++) begin
            chk("rd_valid", out_valid, 1);
            chk("rd_ch", out_ch, i);
            chk("rd_cnt", out_cnt, exp_c[i]);
            step();
        end
        chk("rd_done_busy", busy, 0);
        chk("rd_done_valid", out_valid, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_tick"}, window_tick, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_ch"}, out_ch, 0);
        chk({tag, "_cnt"}, out_cnt, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        window_len = 32'd20;
        spike      = '0;
        out_ready  = 1'b1;
        step();
        check_zero_outputs("reset");
        reset = 1'b0;
        step();

        // Basic count: ch0 x3, ch2 x5
        enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            spike[2] = (k % 2 == 0);
            spike[0] = (k % 2 == 0) && (k < 6);
            step();
        end
        spike = '0;
        wait_tick();
        chk("basic_tick_valid", out_valid, 0);
        step();
        expect_words(3, 0, 5, 0);

        // Boundary spike on ch1 counted in this window and the next
        wait_tick();
        spike = 4'b0010;
        step();
        spike = '0;
        expect_words(0, 1, 0, 0);
        wait_tick();
        step();
        expect_words(0, 1, 0, 0);

        // Backpressure: ch0 x1, ch3 x2, ready low for 7 cycles
        for (int k = 0; k < 4; k++) begin
            spike[3] = (k % 2 == 0);
            spike[0] = (k == 0);
            step();
        end
        spike = '0;
        out_ready = 1'b0;
        wait_tick();
        step();
        for (int k = 0; k < 7; k++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_ch", out_ch, 0);
            chk("bp_cnt", out_cnt, 1);
            step();
        end
        out_ready = 1'b1;
        expect_words(1, 0, 0, 2);

        // Overrun: ch2 x1 in the captured window, then a short window while stalled
        out_ready  = 1'b0;
        window_len = 32'd6;
        spike = 4'b0100;
        step();
        spike = '0;
        step();
        wait_tick();
        step();
        chk("ovr_first_valid", out_valid, 1);
        chk("ovr_first_cnt", out_cnt, 0);
        for (int k = 0; k < 4; k++) begin
            spike[0] = (k % 2 == 0);
            step();
        end
        spike = '0;
        wait_tick();
        chk("ovr_before", overrun, 0);
        step();
        chk("ovr_set", overrun, 1);
        chk("ovr_ch_held", out_ch, 0);
        out_ready = 1'b1;
        expect_words(0, 0, 1, 0);
        chk("ovr_sticky", overrun, 1);

        // Saturation: 10 edges on ch1 in a 30-cycle window
        window_len = 32'd30;
        wait_tick();
        step();
        for (int k = 0; k < 20; k++) begin
            spike[1] = (k % 2 == 0);
            step();
        end
        spike = '0;
        wait_tick();
        window_len = 32'd0;
        step();
        expect_words(0, 7, 0, 0);

        // window_len=0 behaves as 2: tick every other cycle
        wait_tick();
        step();
        chk("len0_tick_a", window_tick, 0);
        step();
        chk("len0_tick_b", window_tick, 1);
        step();
        chk("len0_tick_c", window_tick, 0);

        // Disable: no ticks, readout drains
        window_len = 32'd20;
        enable = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("dis_tick", window_tick, 0);
            step();
        end
        chk("dis_busy", busy, 0);

        // Reset mid-readout
        enable = 1'b1;
        spike = 4'b0001;
        step();
        spike = '0;
        wait_tick();
        step();
        step();
        step();
        chk("rst_mid_ch", out_ch, 2);
        reset = 1'b1;
        #1;
        check_zero_outputs("rst_async");
        step();
        reset = 1'b0;
        spike = 4'b1000;
        step();
        spike = '0;
        wait_tick();
        step();
        expect_words(0, 0, 0, 1);
        chk("post_rst_overrun", overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
